// File: rtl/priority_decoder.sv
// Frame-based priority decoder: collects encoded bit indices over a beat stream
// and presents the resulting bitmap, its popcount and a duplicate flag per frame.
module priority_decoder #(
    parameter int CODE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(2**CODE_W)-1:0] out_bits,
    output logic [CODE_W:0]        out_count,
    output logic                   out_dup
);

    localparam int N = 2**CODE_W;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    acc;
    logic [N-1:0]    acc_nxt;
    logic            dup;
    logic            dup_nxt;
    logic            load;
    logic [N-1:0]    onehot;
    logic [N-1:0]    merged;
    logic            hit;

    function automatic logic [CODE_W:0] popcount(input logic [N-1:0] v);
        logic [CODE_W:0] c;
        // NOTE: blocking '=' is right inside a combinational function; it builds a value, not state.
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + (CODE_W+1)'(v[i]);
        end
        return c;
    endfunction

    assign onehot    = N'(1) << in_code;
    assign hit       = |(acc & onehot);
    assign merged    = acc | onehot;

    // Handshake outputs decode state only, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt = state;
        acc_nxt   = acc;
        dup_nxt   = dup;
        load      = 1'b0;
        case (state)
            ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        load      = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        acc_nxt = merged;
                        dup_nxt = dup | hit;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    dup_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // NOTE: non-blocking '<=' for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            dup   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            dup   <= dup_nxt;
        end
    end

    // Result registers only load on the closing beat; they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bits  <= '0;
            out_count <= '0;
            out_dup   <= 1'b0;
        end else if (load) begin
            out_bits  <= merged;
            out_count <= popcount(merged);
            out_dup   <= dup | hit;
        end
    end

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: directed frames with literal
// expectations plus a per-code occurrence-count model checked every cycle.
module tb_priority_decoder;

    localparam int CODE_W = 3;
    localparam int N      = 2**CODE_W;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [CODE_W-1:0] in_code   = '0;
    logic              in_last   = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N-1:0]      out_bits;
    logic [CODE_W:0]   out_count;
    logic              out_dup;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    priority_decoder #(.CODE_W(CODE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occurrence count per code in the open frame; the result is derived from counts.
    typedef struct packed {
        logic [N-1:0]    bits;
        logic [CODE_W:0] count;
        logic            dup;
    } res_t;

    int   cnt [N];
    bit   m_hold;
    res_t m_res;

    function automatic res_t summarize(input int c [N], input int code);
        res_t r;
        int   t [N];
        t = c;
        t[code] = t[code] + 1;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (t[k] > 0) begin
                r.bits[k] = 1'b1;
                r.count   = r.count + 1'b1;
            end
            if (t[k] > 1) r.dup = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) cnt[k] <= 0;
            m_hold <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold <= 1'b0;
                for (int k = 0; k < N; k++) cnt[k] <= 0;
            end
        end else if (in_valid) begin
            cnt[int'(in_code)] <= cnt[int'(in_code)] + 1;
            if (in_last) begin
                m_hold <= 1'b1;
                m_res  <= summarize(cnt, int'(in_code));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !m_hold);
            check("out_valid", out_valid, m_hold);
            if (m_hold) begin
                check("out_bits", out_bits, m_res.bits);
                check("out_count", out_count, m_res.count);
                check("out_dup", out_dup, m_res.dup);
            end
        end
    end

    // Called at a falling edge; presents a beat and returns at the falling edge after acceptance.
    task automatic send(input logic [CODE_W-1:0] code, input bit last);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_code  = code;
        in_last  = last;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [N-1:0] bits,
                                 input logic [CODE_W:0] count, input logic dup);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_bits"}, out_bits, bits);
        check({name, "_count"}, out_count, count);
        check({name, "_dup"}, out_dup, dup);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bits", out_bits, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_dup", out_dup, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three distinct codes, consumer always ready.
        out_ready = 1'b1;
        send(3'd3, 1'b0);
        send(3'd5, 1'b0);
        send(3'd0, 1'b1);
        idle();
        expect_result("f1", 8'b0010_1001, 4'd3, 1'b0);
        @(negedge clk);
        check("f1_valid_one_cycle", out_valid, 0);
        check("f1_ready_back", in_ready, 1);

        // Repeated code raises dup without counting twice.
        send(3'd7, 1'b0);
        send(3'd2, 1'b0);
        send(3'd7, 1'b1);
        idle();
        expect_result("f2", 8'b1000_0100, 4'd2, 1'b1);
        @(negedge clk);

        // Full bitmap held through a 5-cycle stall with HOLD-state beats ignored.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(CODE_W'(i), i == N - 1);
        idle();
        for (int i = 0; i < 5; i++) begin
            expect_result("f3_stall", 8'hFF, 4'd8, 1'b0);
            check("f3_stall_ready", in_ready, 0);
            in_valid = 1'b1;
            in_code  = CODE_W'(i + 1);
            in_last  = i[0];
            @(negedge clk);
        end
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        check("f3_released", out_valid, 0);
        check("f3_ready_back", in_ready, 1);

        // Single-beat frames back to back, no carry-over.
        send(3'd4, 1'b1);
        idle();
        expect_result("f4", 8'h10, 4'd1, 1'b0);
        @(negedge clk);
        send(3'd1, 1'b1);
        idle();
        expect_result("f5", 8'h02, 4'd1, 1'b0);
        @(negedge clk);

        // Reset between edges discards the partial frame.
        send(3'd1, 1'b0);
        send(3'd6, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(3'd2, 1'b1);
        idle();
        expect_result("f6", 8'h04, 4'd1, 1'b0);
        @(negedge clk);

        // Random beat streams with random consumer stalls, checked by the model.
        fork
            begin
                for (int b = 0; b < 300; b++)
                    send(CODE_W'($urandom_range(N - 1, 0)), $urandom_range(3, 0) == 0);
                send(CODE_W'($urandom_range(N - 1, 0)), 1'b1);
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(1, 0));
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_idle_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 SHALL have parameter CODE_W, default 3, the code width; the output bitmap width is 2**CODE_W.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; the reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit, qualifying a code beat.
REQ-005 SHALL have port in_ready, output, 1 bit; the block accepts a beat when in_valid and in_ready are both high on a clk edge.
REQ-006 SHALL have port in_code, input, CODE_W bits, the encoded bit index (0..2**CODE_W-1).
REQ-007 SHALL have port in_last, input, 1 bit, marking the final beat of a frame.
REQ-008 SHALL have port out_valid, output, 1 bit, marking the decoded frame result as valid.
REQ-009 SHALL have port out_ready, input, 1 bit; the consumer takes the result when out_valid and out_ready are both high.
REQ-010 SHALL have port out_bits, output, 2**CODE_W bits, the decoded bitmap; bit k is set if code k occurred in the frame.
REQ-011 SHALL have port out_count, output, CODE_W+1 bits, the number of set bits in out_bits.
REQ-012 SHALL have port out_dup, output, 1 bit, set if any code occurred more than once in the frame.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM (collecting beats) and HOLD (presenting the result).
REQ-014 SHALL drive in_ready=1 exactly in ACCUM and in_ready=0 exactly in HOLD, as a registered/state-decoded output with no combinational path from out_ready.
REQ-015 SHALL, in ACCUM on each accepted beat, set internal accumulator bit in_code; other accumulator bits are left unchanged.
REQ-016 SHALL set the internal dup flag when an accepted code's accumulator bit is already set, whether from an earlier beat of the same frame or from the same code repeated.
REQ-017 SHALL, on an accepted beat with in_last=1, do all of the following on that same edge: load out_bits with (accumulator OR one-hot(in_code)), load out_count with its popcount, load out_dup with (dup flag OR the current beat's duplicate condition), set out_valid=1, and enter HOLD; latency is one clock from the last-beat edge to out_valid being visible.
REQ-018 SHALL treat a single-beat frame (in_last=1 on the first beat) the same way: out_count=1 and out_dup=0.
REQ-019 SHALL, in HOLD, keep out_bits, out_count and out_dup stable and keep out_valid=1 until accepted, for any duration of out_ready low.
REQ-020 SHALL, in HOLD on out_valid and out_ready, clear out_valid, clear the accumulator and dup flag, and return to ACCUM; in_ready is 1 in the following cycle.
REQ-021 SHALL NOT provide a HOLD-to-ACCUM bypass, so there is one bubble cycle minimum between frames.
REQ-022 SHALL ignore in_valid, in_code and in_last while in HOLD, with no state change.
REQ-023 SHALL hold out_bits, out_count and out_dup at their last values while out_valid=0; they are only meaningful while out_valid=1.
REQ-024 SHALL, when in_valid=0 in ACCUM, change no state.
REQ-025 SHALL reach a maximum out_count of 2**CODE_W (8 at default) without overflow.

Reset
REQ-026 SHALL, on rst_n low at any time (asynchronous), immediately force state=ACCUM, accumulator=0, dup flag=0, out_valid=0, out_bits=0, out_count=0, out_dup=0, and in_ready=1.
REQ-027 SHALL discard any partial frame or unaccepted result on reset mid-operation; the first accepted beat after rst_n deasserts starts a new frame.

Verification
REQ-028 SHALL be covered by this scenario: beats 3,5,0 with in_last on 0, out_ready=1 -> out_bits=8'b0010_1001, out_count=3, out_dup=0, out_valid for 1 cycle, in_ready back to 1 the next cycle.
REQ-029 SHALL be covered by this scenario: beats 7,2,7 (last) -> out_bits=8'b1000_0100, out_count=2, out_dup=1.
REQ-030 SHALL be covered by this scenario: all codes 0..7 (last on 7), with out_ready held low 5 cycles -> out_bits=8'hFF and out_count=8, stable for all 5 cycles, in_ready=0 throughout, and in_valid pulses in HOLD ignored.
REQ-031 SHALL be covered by this scenario: single beat code 4 with last -> out_bits=8'h10, out_count=1, out_dup=0; then an immediate next frame with code 1 last -> out_bits=8'h02, showing no carry-over from the previous frame.
REQ-032 SHALL be covered by this scenario: beats 1,6 (not last), then rst_n pulsed low between clock edges -> out_valid=0 and in_ready=1 immediately; a following frame of code 2 last -> out_bits=8'h04, out_count=1.
REQ-033 SHALL be covered by this scenario: random beat streams with random out_ready stalls -> a scoreboard bitmap, popcount and duplicate model matches every accepted result, and no beat is accepted while in_ready=0.
